aximm_csr_mc: RTL

Multi-channel CSR controller for the AXI-MM example designs; successor to the single-channel CSR controller behind the JTAG-to-Avalon bridge. Sits between the bridge's CSR port (wr_rd_addr/wr_en/rd_en/wr_data) and the AXI-MM traffic generators/checkers. Per-channel data snapshots with arm/capture, sticky W1C error flags, a busy-tracked command launcher and saturating completion counters.

---
 rtl/aximm_csr_pkg.sv | 69 ++++++
 rtl/aximm_csr_chnl_cap.sv | 49 ++++
 rtl/aximm_csr_mc.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/aximm_csr_pkg.sv
// Address map, bit positions and snapshot types shared by the AXI-MM CSR controller.
package aximm_csr_pkg;

  localparam logic [31:0] CSR_ID       = 32'h4D4D_0002;

  localparam logic [15:0] ADDR_ID      = 16'h0000;
  localparam logic [15:0] ADDR_CTRL    = 16'h0004;
  localparam logic [15:0] ADDR_STATUS  = 16'h0008;
  localparam logic [15:0] ADDR_STICKY  = 16'h000C;
  localparam logic [15:0] ADDR_DLY_X   = 16'h0010;
  localparam logic [15:0] ADDR_DLY_Y   = 16'h0014;
  localparam logic [15:0] ADDR_DLY_Z   = 16'h0018;
  localparam logic [15:0] ADDR_RW_ADDR = 16'h0020;
  localparam logic [15:0] ADDR_RW_CFG  = 16'h0024;
  localparam logic [15:0] ADDR_WR_CNT  = 16'h0028;
  localparam logic [15:0] ADDR_RD_CNT  = 16'h002C;

  localparam logic [15:0] CHNL_BASE    = 16'h0100;
  localparam logic [15:0] CHNL_STRIDE  = 16'h0020;

  localparam int CTRL_RSTN       = 0;
  localparam int CTRL_WR_GO      = 1;
  localparam int CTRL_RD_GO      = 2;
  localparam int CTRL_CAP_ARM    = 3;

  localparam int STAT_WR_BUSY    = 0;
  localparam int STAT_RD_BUSY    = 1;
  localparam int STAT_CHKR_LSB   = 2;
  localparam int STAT_ONLINE_LSB = 4;

  localparam int STK_ALIGN       = 0;
  localparam int STK_F2L_ALIGN   = 1;
  localparam int STK_WR_CMPL     = 2;
  localparam int STK_RD_CMPL     = 3;
  localparam int STK_OVERRUN     = 4;
  localparam int STK_W           = 5;

  typedef enum logic [2:0] {
    SNAP_OUT_FIRST_LO = 3'd0,
    SNAP_OUT_FIRST_HI = 3'd1,
    SNAP_OUT_LAST_LO  = 3'd2,
    SNAP_OUT_LAST_HI  = 3'd3,
    SNAP_IN_FIRST_LO  = 3'd4,
    SNAP_IN_FIRST_HI  = 3'd5,
    SNAP_IN_LAST_LO   = 3'd6,
    SNAP_IN_LAST_HI   = 3'd7
  } snap_word_e;

  typedef struct packed {
    logic [63:0] out_first;
    logic [63:0] out_last;
    logic [63:0] in_first;
    logic [63:0] in_last;
  } chnl_snap_t;

  function automatic logic [31:0] snap_word(input chnl_snap_t s, input snap_word_e sel);
    case (sel)
      SNAP_OUT_FIRST_LO: snap_word = s.out_first[31:0];
      SNAP_OUT_FIRST_HI: snap_word = s.out_first[63:32];
      SNAP_OUT_LAST_LO:  snap_word = s.out_last[31:0];
      SNAP_OUT_LAST_HI:  snap_word = s.out_last[63:32];
      SNAP_IN_FIRST_LO:  snap_word = s.in_first[31:0];
      SNAP_IN_FIRST_HI:  snap_word = s.in_first[63:32];
      SNAP_IN_LAST_LO:   snap_word = s.in_last[31:0];
      default:           snap_word = s.in_last[63:32];
    endcase
  endfunction

endpackage

// File: rtl/aximm_csr_chnl_cap.sv
// One channel's four 64-bit data snapshots; *_first loads once per arm, *_last on every valid.
// Single-cycle capture, no backpressure: valids are sampled unconditionally.
module aximm_csr_chnl_cap
  import aximm_csr_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        arm_i,
  input  logic [63:0] out_first_i,
  input  logic [63:0] out_last_i,
  input  logic [63:0] in_first_i,
  input  logic [63:0] in_last_i,
  input  logic        out_first_vld_i,
  input  logic        out_last_vld_i,
  input  logic        in_first_vld_i,
  input  logic        in_last_vld_i,
  output chnl_snap_t  snap_o
);

  chnl_snap_t snap_q, snap_d;
  logic       out_arm_q, out_arm_d;
  logic       in_arm_q, in_arm_d;

  // A fresh arm in the same cycle as a capture re-arms for the next beat.
  always_comb begin
    snap_d = snap_q;
    if (out_first_vld_i && out_arm_q) snap_d.out_first = out_first_i;
    if (out_last_vld_i)               snap_d.out_last  = out_last_i;
    if (in_first_vld_i && in_arm_q)   snap_d.in_first  = in_first_i;
    if (in_last_vld_i)                snap_d.in_last   = in_last_i;
    out_arm_d = arm_i || (out_arm_q && !out_first_vld_i);
    in_arm_d  = arm_i || (in_arm_q && !in_first_vld_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_q    <= '0;
      out_arm_q <= 1'b0;
      in_arm_q  <= 1'b0;
    end else begin
      snap_q    <= snap_d;
      out_arm_q <= out_arm_d;
      in_arm_q  <= in_arm_d;
    end
  end

  assign snap_o = snap_q;

endmodule

// File: rtl/aximm_csr_mc.sv
// Multi-channel CSR block for the AXI-MM example designs: config, launch/busy, sticky flags, counters, snapshots.
// Reads return one cycle after rd_en; writes take effect next cycle; no backpressure on the CSR port.
module aximm_csr_mc
  import aximm_csr_pkg::*;
#(
  parameter int AXI_CHNL_NUM = 1,
  parameter int CNT_W        = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [15:0]               wr_rd_addr,
  input  logic                      wr_en,
  input  logic                      rd_en,
  input  logic [31:0]               wr_data,
  output logic [31:0]               rd_datain,
  output logic                      rd_dvalid,
  input  logic [AXI_CHNL_NUM*64-1:0] data_out_first,
  input  logic [AXI_CHNL_NUM*64-1:0] data_out_last,
  input  logic [AXI_CHNL_NUM*64-1:0] data_in_first,
  input  logic [AXI_CHNL_NUM*64-1:0] data_in_last,
  input  logic [AXI_CHNL_NUM-1:0]   data_out_first_valid,
  input  logic [AXI_CHNL_NUM-1:0]   data_out_last_valid,
  input  logic [AXI_CHNL_NUM-1:0]   data_in_first_valid,
  input  logic [AXI_CHNL_NUM-1:0]   data_in_last_valid,
  input  logic [1:0]                chkr_pass,
  input  logic                      align_error,
  input  logic                      f2l_align_error,
  input  logic                      read_complete,
  input  logic                      write_complete,
  input  logic                      ldr_tx_online,
  input  logic                      ldr_rx_online,
  input  logic                      fllr_tx_online,
  input  logic                      fllr_rx_online,
  output logic [31:0]               o_delay_x_value,
  output logic [31:0]               o_delay_y_value,
  output logic [31:0]               o_delay_z_value,
  output logic                      axist_rstn_out,
  output logic                      aximm_wr,
  output logic                      aximm_rd,
  output logic [7:0]                aximm_rw_length,
  output logic [1:0]                aximm_rw_burst,
  output logic [2:0]                aximm_rw_size,
  output logic [31:0]               aximm_rw_addr
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic              rstn_q, rstn_d;
  logic              wr_busy_q, wr_busy_d, rd_busy_q, rd_busy_d;
  logic              aximm_wr_q, aximm_rd_q;
  logic [STK_W-1:0]  sticky_q, sticky_d, sticky_set, sticky_clr;
  logic [31:0]       dly_x_q, dly_x_d, dly_y_q, dly_y_d, dly_z_q, dly_z_d;
  logic [31:0]       rw_addr_q, rw_addr_d;
  logic [7:0]        rw_len_q, rw_len_d;
  logic [1:0]        rw_burst_q, rw_burst_d;
  logic [2:0]        rw_size_q, rw_size_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic              rd_dvalid_q;
  logic [31:0]       rd_datain_q, rd_datain_d, rdata;
  logic [15:0]       chnl_base;

  logic ctrl_wr, wr_go, rd_go, cap_arm, wr_launch, rd_launch;

  chnl_snap_t snap [AXI_CHNL_NUM];

  assign ctrl_wr   = wr_en && (wr_rd_addr == ADDR_CTRL);
  assign wr_go     = ctrl_wr && wr_data[CTRL_WR_GO];
  assign rd_go     = ctrl_wr && wr_data[CTRL_RD_GO];
  assign cap_arm   = ctrl_wr && wr_data[CTRL_CAP_ARM];
  assign wr_launch = wr_go && !wr_busy_q;
  assign rd_launch = rd_go && !rd_busy_q;

  for (genvar c = 0; c < AXI_CHNL_NUM; c++) begin : g_chnl
    aximm_csr_chnl_cap u_cap (
      .clk             (clk),
      .rst             (rst),
      .arm_i           (cap_arm),
      .out_first_i     (data_out_first[64*c +: 64]),
      .out_last_i      (data_out_last[64*c +: 64]),
      .in_first_i      (data_in_first[64*c +: 64]),
      .in_last_i       (data_in_last[64*c +: 64]),
      .out_first_vld_i (data_out_first_valid[c]),
      .out_last_vld_i  (data_out_last_valid[c]),
      .in_first_vld_i  (data_in_first_valid[c]),
      .in_last_vld_i   (data_in_last_valid[c]),
      .snap_o          (snap[c])
    );
  end

  // Read mux sees pre-write state, so a same-cycle write/read returns the old value.
  always_comb begin
    rdata     = '0;
    chnl_base = '0;
    case (wr_rd_addr)
      ADDR_ID:      rdata = CSR_ID;
      ADDR_CTRL:    rdata[CTRL_RSTN] = rstn_q;
      ADDR_STATUS: begin
        rdata[STAT_WR_BUSY]          = wr_busy_q;
        rdata[STAT_RD_BUSY]          = rd_busy_q;
        rdata[STAT_CHKR_LSB +: 2]    = chkr_pass;
        rdata[STAT_ONLINE_LSB +: 4]  = {fllr_rx_online, fllr_tx_online, ldr_rx_online, ldr_tx_online};
      end
      ADDR_STICKY:  rdata[STK_W-1:0] = sticky_q;
      ADDR_DLY_X:   rdata = dly_x_q;
      ADDR_DLY_Y:   rdata = dly_y_q;
      ADDR_DLY_Z:   rdata = dly_z_q;
      ADDR_RW_ADDR: rdata = rw_addr_q;
      ADDR_RW_CFG: begin
        rdata[7:0]   = rw_len_q;
        rdata[9:8]   = rw_burst_q;
        rdata[14:12] = rw_size_q;
      end
      ADDR_WR_CNT:  rdata = 32'(wr_cnt_q);
      ADDR_RD_CNT:  rdata = 32'(rd_cnt_q);
      default:      ;
    endcase
    for (int c = 0; c < AXI_CHNL_NUM; c++) begin
      chnl_base = CHNL_BASE + CHNL_STRIDE * 16'(c);
      if ({wr_rd_addr[15:5], 5'b0_0000} == chnl_base && wr_rd_addr[1:0] == 2'b00)
        rdata = snap_word(snap[c], snap_word_e'(wr_rd_addr[4:2]));
    end
  end

  always_comb begin
    rstn_d     = ctrl_wr ? wr_data[CTRL_RSTN] : rstn_q;
    dly_x_d    = (wr_en && wr_rd_addr == ADDR_DLY_X)   ? wr_data : dly_x_q;
    dly_y_d    = (wr_en && wr_rd_addr == ADDR_DLY_Y)   ? wr_data : dly_y_q;
    dly_z_d    = (wr_en && wr_rd_addr == ADDR_DLY_Z)   ? wr_data : dly_z_q;
    rw_addr_d  = (wr_en && wr_rd_addr == ADDR_RW_ADDR) ? wr_data : rw_addr_q;
    rw_len_d   = rw_len_q;
    rw_burst_d = rw_burst_q;
    rw_size_d  = rw_size_q;
    if (wr_en && wr_rd_addr == ADDR_RW_CFG) begin
      rw_len_d   = wr_data[7:0];
      rw_burst_d = wr_data[9:8];
      rw_size_d  = wr_data[14:12];
    end

    // A go that arrives with its own completion is still rejected; busy simply drops.
    wr_busy_d = wr_launch ? 1'b1 : (write_complete ? 1'b0 : wr_busy_q);
    rd_busy_d = rd_launch ? 1'b1 : (read_complete  ? 1'b0 : rd_busy_q);

    sticky_set                = '0;
    sticky_set[STK_ALIGN]     = align_error;
    sticky_set[STK_F2L_ALIGN] = f2l_align_error;
    sticky_set[STK_WR_CMPL]   = write_complete;
    sticky_set[STK_RD_CMPL]   = read_complete;
    sticky_set[STK_OVERRUN]   = (wr_go && wr_busy_q) || (rd_go && rd_busy_q);
    sticky_clr = (wr_en && wr_rd_addr == ADDR_STICKY) ? wr_data[STK_W-1:0] : '0;
    sticky_d   = (sticky_q & ~sticky_clr) | sticky_set;

    wr_cnt_d = wr_cnt_q;
    if (wr_en && wr_rd_addr == ADDR_WR_CNT)
      wr_cnt_d = write_complete ? CNT_ONE : '0;
    else if (write_complete && wr_cnt_q != '1)
      wr_cnt_d = wr_cnt_q + CNT_ONE;

    rd_cnt_d = rd_cnt_q;
    if (wr_en && wr_rd_addr == ADDR_RD_CNT)
      rd_cnt_d = read_complete ? CNT_ONE : '0;
    else if (read_complete && rd_cnt_q != '1)
      rd_cnt_d = rd_cnt_q + CNT_ONE;

    rd_datain_d = rd_en ? rdata : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstn_q      <= 1'b0;
      wr_busy_q   <= 1'b0;
      rd_busy_q   <= 1'b0;
      aximm_wr_q  <= 1'b0;
      aximm_rd_q  <= 1'b0;
      sticky_q    <= '0;
      dly_x_q     <= '0;
      dly_y_q     <= '0;
      dly_z_q     <= '0;
      rw_addr_q   <= '0;
      rw_len_q    <= '0;
      rw_burst_q  <= '0;
      rw_size_q   <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      rd_dvalid_q <= 1'b0;
      rd_datain_q <= '0;
    end else begin
      rstn_q      <= rstn_d;
      wr_busy_q   <= wr_busy_d;
      rd_busy_q   <= rd_busy_d;
      aximm_wr_q  <= wr_launch;
      aximm_rd_q  <= rd_launch;
      sticky_q    <= sticky_d;
      dly_x_q     <= dly_x_d;
      dly_y_q     <= dly_y_d;
      dly_z_q     <= dly_z_d;
      rw_addr_q   <= rw_addr_d;
      rw_len_q    <= rw_len_d;
      rw_burst_q  <= rw_burst_d;
      rw_size_q   <= rw_size_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_dvalid_q <= rd_en;
      rd_datain_q <= rd_datain_d;
    end
  end

  assign rd_datain       = rd_datain_q;
  assign rd_dvalid       = rd_dvalid_q;
  assign axist_rstn_out  = rstn_q;
  assign aximm_wr        = aximm_wr_q;
  assign aximm_rd        = aximm_rd_q;
  assign o_delay_x_value = dly_x_q;
  assign o_delay_y_value = dly_y_q;
  assign o_delay_z_value = dly_z_q;
  assign aximm_rw_addr   = rw_addr_q;
  assign aximm_rw_length = rw_len_q;
  assign aximm_rw_burst  = rw_burst_q;
  assign aximm_rw_size   = rw_size_q;

endmodule
